// File: rtl/prbs_wide_check.sv
// Wide PRBS-31 receive checker: self-synchronises on the incoming word stream,
// then compares each word against a free-running local LFSR and counts errors.
module prbs_wide_check #(
   parameter int WIDTH        = 32,
   parameter int TAP1         = 30,
   parameter int TAP2         = 27,
   parameter int LOCK_WORDS   = 8,
   parameter int UNLOCK_WORDS = 4,
   parameter int UNLOCK_BITS  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             lock_lost,
   output logic             err_valid,
   output logic [WIDTH-1:0] err_mask,
   output logic [31:0]      err_bits,
   output logic [31:0]      words_checked
);

   localparam int HW   = TAP1 + 1;
   localparam int HCW  = $clog2(LOCK_WORDS + 1);
   localparam int BCW  = $clog2(UNLOCK_WORDS + 1);
   localparam int POPW = $clog2(WIDTH + 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   // Unrolls the serial recurrence WIDTH times; the first generated bit lands in the MSB.
   function automatic logic [WIDTH-1:0] expand(input logic [HW-1:0] s);
      logic [HW-1:0]    st;
      logic [WIDTH-1:0] res;
      logic             nb;
      st  = s;
      res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         nb             = st[TAP1] ^ st[TAP2];
         st             = {st[HW-2:0], nb};
         res[WIDTH-1-i] = nb;
      end
      return res;
   endfunction

   state_t           r_state;
   logic [HCW-1:0]   r_huntCnt;
   logic [BCW-1:0]   r_badCnt;
   logic             r_primed;
   logic [HW-1:0]    r_hist;
   logic [HW-1:0]    r_lfsr;
   logic             r_lockLost;
   logic             r_errValid;
   logic [WIDTH-1:0] r_errMask;
   logic [POPW-1:0]  r_popReg;
   logic [31:0]      r_errBits;
   logic [31:0]      r_wordsChecked;

   state_t           w_stateNext;
   logic [HCW-1:0]   w_huntNext;
   logic [BCW-1:0]   w_badNext;
   logic             w_primedNext;
   logic [HW-1:0]    w_lfsrNext;
   logic             w_lockLostNext;
   logic [WIDTH-1:0] w_exp;
   logic [WIDTH-1:0] w_mismatch;
   logic [POPW-1:0]  w_popCnt;
   logic [32:0]      w_errSum;

   // The first word after entering HUNT has no valid predecessor, so it only primes.
   always_comb begin
      w_stateNext    = r_state;
      w_huntNext     = r_huntCnt;
      w_badNext      = r_badCnt;
      w_primedNext   = r_primed;
      w_lfsrNext     = r_lfsr;
      w_lockLostNext = 1'b0;
      w_exp          = expand((r_state == LOCKED) ? r_lfsr : r_hist);
      w_mismatch     = data_in ^ w_exp;
      w_popCnt       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_popCnt = w_popCnt + POPW'(w_mismatch[i]);
      end
      if (data_valid) begin
         case (r_state)
            HUNT: begin
               if (!r_primed) begin
                  w_primedNext = 1'b1;
                  w_huntNext   = '0;
               end else if (w_mismatch == '0 && data_in != '0) begin
                  if (r_huntCnt == HCW'(LOCK_WORDS - 1)) begin
                     w_stateNext = LOCKED;
                     w_lfsrNext  = data_in[HW-1:0];
                     w_huntNext  = '0;
                     w_badNext   = '0;
                  end else begin
                     w_huntNext = r_huntCnt + HCW'(1);
                  end
               end else begin
                  w_huntNext = '0;
               end
            end
            LOCKED: begin
               // Advance on the prediction, not the received data, so errors are not multiplied.
               w_lfsrNext = w_exp[HW-1:0];
               if (int'(w_popCnt) > UNLOCK_BITS) begin
                  if (r_badCnt == BCW'(UNLOCK_WORDS - 1)) begin
                     w_stateNext    = HUNT;
                     w_lockLostNext = 1'b1;
                     w_huntNext     = '0;
                     w_badNext      = '0;
                     w_primedNext   = 1'b0;
                  end else begin
                     w_badNext = r_badCnt + BCW'(1);
                  end
               end else begin
                  w_badNext = '0;
               end
            end
            default: w_stateNext = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= HUNT;
         r_huntCnt  <= '0;
         r_badCnt   <= '0;
         r_primed   <= 1'b0;
         r_lfsr     <= '0;
         r_lockLost <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_huntCnt  <= w_huntNext;
         r_badCnt   <= w_badNext;
         r_primed   <= w_primedNext;
         r_lfsr     <= w_lfsrNext;
         r_lockLost <= w_lockLostNext;
      end
   end

   assign w_errSum = {1'b0, r_errBits} + 33'(r_popReg);

   // Counters trail err_mask by one cycle, using the popcount registered alongside it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hist         <= '0;
         r_errValid     <= 1'b0;
         r_errMask      <= '0;
         r_popReg       <= '0;
         r_errBits      <= '0;
         r_wordsChecked <= '0;
      end else begin
         r_errValid <= data_valid && (r_state == LOCKED);
         if (data_valid) begin
            r_hist <= data_in[HW-1:0];
            if (r_state == LOCKED) begin
               r_errMask <= w_mismatch;
               r_popReg  <= w_popCnt;
            end
         end
         if (clear_cnt) begin
            r_errBits      <= '0;
            r_wordsChecked <= '0;
         end else if (r_errValid) begin
            r_errBits <= w_errSum[32] ? 32'hFFFF_FFFF : w_errSum[31:0];
            if (r_wordsChecked != 32'hFFFF_FFFF) begin
               r_wordsChecked <= r_wordsChecked + 32'd1;
            end
         end
      end
   end

   assign locked        = (r_state == LOCKED);
   assign lock_lost     = r_lockLost;
   assign err_valid     = r_errValid;
   assign err_mask      = r_errMask;
   assign err_bits      = r_errBits;
   assign words_checked = r_wordsChecked;

endmodule

// File: tb/tb_prbs_wide_check.sv
// Bench for prbs_wide_check: directed lock/unlock/clear scenarios plus a randomized
// stream, every cycle compared against a serial-bit reference model of the checker.
module tb_prbs_wide_check;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_valid;
   logic        clear_cnt;
   logic [31:0] data_in;
   logic        locked;
   logic        lock_lost;
   logic        err_valid;
   logic [31:0] err_mask;
   logic [31:0] err_bits;
   logic [31:0] words_checked;

   int checks   = 0;
   int failures = 0;

   logic [30:0] genState = 31'h1;

   bit          mLocked    = 1'b0;
   bit          mPrimed    = 1'b0;
   bit          mLockLost  = 1'b0;
   bit          mErrValid  = 1'b0;
   bit          mPendValid = 1'b0;
   int          mHunt      = 0;
   int          mBad       = 0;
   int          mPendPop   = 0;
   logic [30:0] mHist      = '0;
   logic [30:0] mLfsr      = '0;
   logic [31:0] mErrMask   = '0;
   logic [31:0] mErrBits   = '0;
   logic [31:0] mWords     = '0;

   always #5 clk = ~clk;

   prbs_wide_check dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .clear_cnt     (clear_cnt),
      .locked        (locked),
      .lock_lost     (lock_lost),
      .err_valid     (err_valid),
      .err_mask      (err_mask),
      .err_bits      (err_bits),
      .words_checked (words_checked)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Continues the serial sequence b[n] = b[n-31] ^ b[n-28] for 32 bits after the given history.
   function automatic logic [31:0] extendStream(input logic [30:0] last31);
      bit          q[$];
      bit          nb;
      logic [31:0] w;
      w = '0;
      for (int k = 30; k >= 0; k--) q.push_back(last31[k]);
      for (int i = 0; i < 32; i++) begin
         nb = q[q.size()-31] ^ q[q.size()-28];
         q.push_back(nb);
         w[31-i] = nb;
      end
      return w;
   endfunction

   task automatic nextGenWord(output logic [31:0] w);
      w        = extendStream(genState);
      genState = w[30:0];
   endtask

   task automatic modelEdge(input bit rst, input bit v, input logic [31:0] d, input bit clr);
      logic [31:0] e;
      int          pop;
      longint      sum;
      if (rst) begin
         mLocked = 0; mPrimed = 0; mLockLost = 0; mErrValid = 0; mPendValid = 0;
         mHunt = 0; mBad = 0; mPendPop = 0;
         mHist = '0; mLfsr = '0; mErrMask = '0; mErrBits = '0; mWords = '0;
         return;
      end
      if (clr) begin
         mErrBits = '0;
         mWords   = '0;
      end else if (mPendValid) begin
         sum = mErrBits;
         sum = sum + mPendPop;
         mErrBits = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
         if (mWords != 32'hFFFF_FFFF) mWords = mWords + 1;
      end
      mPendValid = 0;
      mLockLost  = 0;
      mErrValid  = 0;
      if (v) begin
         if (mLocked) begin
            e          = extendStream(mLfsr);
            mErrMask   = d ^ e;
            pop        = $countones(d ^ e);
            mErrValid  = 1;
            mPendValid = 1;
            mPendPop   = pop;
            mLfsr      = e[30:0];
            if (pop > 8) mBad++;
            else mBad = 0;
            if (mBad == 4) begin
               mLocked = 0; mLockLost = 1; mHunt = 0; mBad = 0; mPrimed = 0;
            end
         end else if (!mPrimed) begin
            mPrimed = 1;
            mHunt   = 0;
         end else begin
            e = extendStream(mHist);
            if (d == e && d != 0) mHunt++;
            else mHunt = 0;
            if (mHunt == 8) begin
               mLocked = 1; mLfsr = d[30:0]; mHunt = 0; mBad = 0;
            end
         end
         mHist = d[30:0];
      end
   endtask

   task automatic checkAll();
      checkOutput("locked", {31'b0, locked}, {31'b0, mLocked});
      checkOutput("lock_lost", {31'b0, lock_lost}, {31'b0, mLockLost});
      checkOutput("err_valid", {31'b0, err_valid}, {31'b0, mErrValid});
      if (mErrValid) checkOutput("err_mask", err_mask, mErrMask);
      checkOutput("err_bits", err_bits, mErrBits);
      checkOutput("words_checked", words_checked, mWords);
   endtask

   task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] d, input bit clr);
      reset      = rst;
      data_valid = v;
      data_in    = d;
      clear_cnt  = clr;
      @(posedge clk);
      modelEdge(rst, v, d, clr);
      #1;
      checkAll();
   endtask

   task automatic sendClean(input int n);
      logic [31:0] w;
      for (int i = 0; i < n; i++) begin
         nextGenWord(w);
         applyStimulus(0, 1, w, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, $urandom, 0);
   endtask

   initial begin
      logic [31:0] w;
      int          invLeft;
      bit          v;
      bit          clr;
      bit          rst;
      int          r;

      applyStimulus(1, 0, '0, 0);
      applyStimulus(1, 1, 32'hDEAD_BEEF, 1);
      checkOutput("rst_locked", {31'b0, locked}, 32'd0);
      checkOutput("rst_err_mask", err_mask, 32'd0);
      checkOutput("rst_err_bits", err_bits, 32'd0);

      // Clean stream from generator state 1: lock on word 9, then 1000 clean words.
      genState = 31'h1;
      sendClean(8);
      checkOutput("no_lock_at_8", {31'b0, locked}, 32'd0);
      sendClean(1);
      checkOutput("lock_at_9", {31'b0, locked}, 32'd1);
      sendClean(1);
      checkOutput("first_err_valid", {31'b0, err_valid}, 32'd1);
      checkOutput("first_err_mask", err_mask, 32'd0);
      sendClean(999);
      idle(2);
      checkOutput("clean_words_1000", words_checked, 32'd1000);
      checkOutput("clean_err_bits", err_bits, 32'd0);

      // Single flipped bit 5.
      nextGenWord(w);
      applyStimulus(0, 1, w ^ 32'h20, 0);
      checkOutput("bit5_mask", err_mask, 32'h20);
      sendClean(1);
      checkOutput("bit5_next_mask", err_mask, 32'd0);
      checkOutput("bit5_err_bits", err_bits, 32'd1);
      checkOutput("bit5_still_locked", {31'b0, locked}, 32'd1);

      // Four inverted words drop lock; clean data relocks after 9 valid words.
      for (int i = 0; i < 4; i++) begin
         nextGenWord(w);
         applyStimulus(0, 1, ~w, 0);
      end
      checkOutput("inv_unlocked", {31'b0, locked}, 32'd0);
      checkOutput("inv_lock_lost", {31'b0, lock_lost}, 32'd1);
      sendClean(1);
      checkOutput("inv_lock_lost_pulse", {31'b0, lock_lost}, 32'd0);
      checkOutput("inv_err_bits", err_bits, 32'd129);
      sendClean(7);
      checkOutput("relock_not_yet", {31'b0, locked}, 32'd0);
      sendClean(1);
      checkOutput("relock", {31'b0, locked}, 32'd1);

      // Stuck-at lines never lock.
      applyStimulus(1, 0, '0, 0);
      for (int i = 0; i < 100; i++) applyStimulus(0, 1, 32'h0, 0);
      checkOutput("zeros_no_lock", {31'b0, locked}, 32'd0);
      for (int i = 0; i < 100; i++) applyStimulus(0, 1, 32'hFFFF_FFFF, 0);
      checkOutput("ones_no_lock", {31'b0, locked}, 32'd0);

      // data_valid toggling every cycle.
      applyStimulus(1, 0, '0, 0);
      genState = 31'h1;
      for (int i = 0; i < 9; i++) begin
         sendClean(1);
         idle(1);
      end
      checkOutput("toggle_lock", {31'b0, locked}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         sendClean(1);
         idle(1);
      end
      idle(2);
      checkOutput("toggle_words", words_checked, 32'd20);

      // clear_cnt held across the error word and its counter update.
      nextGenWord(w);
      applyStimulus(0, 1, w ^ 32'h20, 1);
      checkOutput("clr_err_mask", err_mask, 32'h20);
      nextGenWord(w);
      applyStimulus(0, 1, w, 1);
      nextGenWord(w);
      applyStimulus(0, 1, w, 0);
      checkOutput("clr_err_bits", err_bits, 32'd0);
      checkOutput("clr_words", words_checked, 32'd1);

      // Reset while locked.
      nextGenWord(w);
      applyStimulus(1, 1, w, 1);
      checkOutput("midrst_locked", {31'b0, locked}, 32'd0);
      checkOutput("midrst_lock_lost", {31'b0, lock_lost}, 32'd0);
      checkOutput("midrst_err_valid", {31'b0, err_valid}, 32'd0);
      checkOutput("midrst_err_mask", err_mask, 32'd0);
      checkOutput("midrst_err_bits", err_bits, 32'd0);
      checkOutput("midrst_words", words_checked, 32'd0);
      sendClean(8);
      checkOutput("midrst_no_lock", {31'b0, locked}, 32'd0);
      sendClean(1);
      checkOutput("midrst_relock", {31'b0, locked}, 32'd1);

      // Randomized stream: gaps, bit errors, inversion bursts, clears, rare resets.
      invLeft = 0;
      for (int c = 0; c < 4000; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 199) == 0);
         rst = ($urandom_range(0, 999) == 0);
         if (v) begin
            nextGenWord(w);
            r = $urandom_range(0, 99);
            if (invLeft > 0) begin
               w = ~w;
               invLeft--;
            end else if (r < 5) begin
               w = w ^ (32'd1 << $urandom_range(0, 31));
            end else if (r < 7) begin
               w = w ^ $urandom;
            end else if (r < 8) begin
               invLeft = $urandom_range(1, 6);
            end
         end else begin
            w = $urandom;
         end
         applyStimulus(rst, v, w, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs_wide_check.md
Name: prbs_wide_check

Overview:
- Receive-side checker for the wide PRBS-31 generator (polynomial x^31+x^28+1, taps 30/27, WIDTH bits per clock).
- Self-synchronises to an incoming word stream, then checks it against a free-running local LFSR.
- Reports a per-bit error mask, saturating error/word counters and lock status.
- Sits at the BER tester receive path, after the link/deserialiser.

Parameters:
- WIDTH, 32: bits per word. Must be >= TAP1+1.
- TAP1, 30: first feedback tap; history length is TAP1+1 = 31.
- TAP2, 27: second feedback tap.
- LOCK_WORDS, 8: consecutive clean non-zero words needed to lock.
- UNLOCK_WORDS, 4: consecutive bad words needed to drop lock.
- UNLOCK_BITS, 8: a word is bad if its bit-error count is > UNLOCK_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  received word; bit WIDTH-1 is the oldest bit in time.
- data_valid  in  1  data_in is valid this cycle.
- clear_cnt  in  1  synchronous clear of err_bits and words_checked.
- locked  out  1  checker is in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_valid  out  1  err_mask is valid (word was checked while LOCKED).
- err_mask  out  WIDTH  1 = bit mismatch.
- err_bits  out  32  saturating count of bit errors while LOCKED.
- words_checked  out  32  saturating count of words checked while LOCKED.

Behaviour:
- Sequence definition:
  - Serial bit b[n] = b[n-31] ^ b[n-28].
  - A word carries 32 consecutive bits, oldest in bit WIDTH-1, newest in bit 0.
- Prediction function:
  - E(S) expands a 31-bit state S (S[0] = newest bit) into the next WIDTH expected bits.
  - It iteratively shifts S left and feeds S[TAP1]^S[TAP2] in at bit 0.
  - Combinational; all WIDTH bits are produced in one cycle.
- State:
  - hist[30:0]: low 31 bits of the last valid data_in.
  - lfsr[30:0]: local generator state.
  - hunt_cnt, bad_cnt, fsm.
- FSM states: HUNT (reset state) and LOCKED.
- Words with data_valid=0 change nothing: no state, counter or history update, and err_valid=0 next cycle.
- HUNT:
  - exp = E(hist); mismatch = data_in ^ exp.
  - The first valid word after reset or after entering HUNT only primes hist; hunt_cnt stays 0.
  - A valid word with mismatch==0 and data_in!=0 increments hunt_cnt. Any other valid word clears hunt_cnt.
  - All-zero words never count, so a stuck-at-0 line cannot lock.
  - When hunt_cnt reaches LOCK_WORDS on a valid word: go to LOCKED and load lfsr <= data_in[30:0].
  - hist <= data_in[30:0] on every valid word.
  - err_valid stays 0 in HUNT.
- LOCKED:
  - exp = E(lfsr); err_mask <= data_in ^ exp; err_valid <= 1 (both registered, visible one cycle after the sampling edge).
  - lfsr <= exp[30:0] regardless of errors, so each flipped bit counts exactly once (no x3 error multiplication).
  - Word errors = popcount(mismatch). If > UNLOCK_BITS, bad_cnt increments; otherwise bad_cnt clears.
  - When bad_cnt reaches UNLOCK_WORDS: go to HUNT, pulse lock_lost for one cycle, clear hunt_cnt and bad_cnt.
  - The next valid word after that only primes hist.
- Counters:
  - Registered popcount; updated one cycle after err_mask, i.e. two cycles after the data edge.
  - err_bits += popcount; words_checked += 1. Both saturate at 0xFFFFFFFF.
  - Counters hold their value across HUNT periods.
- clear_cnt: zeroes both counters. It wins over a same-cycle increment, which is dropped. It does not affect FSM, lfsr, hist or err_mask.
- Reset: all outputs 0 (locked=0, lock_lost=0, err_valid=0, err_mask=0, err_bits=0, words_checked=0). FSM=HUNT; hist, lfsr, hunt_cnt, bad_cnt = 0. Reset is honoured mid-lock and overrides clear_cnt and data_valid.
- No combinational path from inputs to outputs.

Test Plan:
- Generator reset (state 1) drives the checker with data_valid=1 continuously -> locked rises after word 1+LOCK_WORDS=9, on the following edge. Then err_valid=1, err_mask=0; after 1000 words, err_bits=0 and words_checked=1000 (with pipeline offset).
- Once locked, flip bit 5 of a single word -> exactly one err_mask with only bit 5 set; err_bits increments by 1; next word err_mask=0; locked stays 1.
- Constant data_in=0 for 100 words -> locked never asserts; hunt_cnt stays 0. Same for 0xFFFFFFFF: mismatch nonzero, no lock.
- Once locked, invert 4 consecutive words (32 errors each) -> lock_lost pulses once; locked=0; err_bits += 128. Restore clean data -> relock after 9 valid words.
- Toggle data_valid 1/0 every cycle on a clean stream -> lock after 9 valid words; words_checked counts only valid words.
- clear_cnt in the same cycle as a counted error -> err_bits=0 afterwards. Reset asserted while locked -> all outputs 0 next cycle, then relock after 9 valid words.
